// File: rtl/lc3_pkg.sv
// Purpose: shared LC3 memory-interface types (controller op codes, arbiter FSM states).
// Latency: n/a, types only.
// Backpressure: n/a.
package lc3_pkg;

    // Data-side op code driven by the controller; MEM_IDLE means no data access wanted.
    typedef enum logic [1:0] {
        MEM_RD   = 2'd0,
        MEM_IND  = 2'd1,
        MEM_WR   = 2'd2,
        MEM_IDLE = 2'd3
    } mem_state_t;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_INSTR = 3'd1,
        ARB_DRD   = 3'd2,
        ARB_DIND  = 3'd3,
        ARB_DWR   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/lc3_mem_arbiter.sv
// Purpose: shares one single-port memory between fetch and the data side, incl. indirect chains.
// Latency: grant -> mem_en next cycle; completion pulse the cycle after mem_ready is sampled.
// Backpressure: mem_en/addr held until mem_ready or MAX_WAIT timeout; requesters wait for complete_*.
module lc3_mem_arbiter
    import lc3_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_req,
    input  logic [AW-1:0] instr_addr,
    input  logic [1:0]    mem_state,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_din,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] instr_dout,
    output logic          complete_instr,
    output logic [DW-1:0] data_dout,
    output logic          complete_data,
    output logic          mem_err
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    mem_state_t    op_in;
    arb_state_t    state, state_nxt;
    mem_state_t    served_op, served_op_nxt;
    logic          ind_valid, ind_valid_nxt;
    logic [AW-1:0] ind_ptr, ind_ptr_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic [SW-1:0] starve_cnt, starve_cnt_nxt;
    // Set for the one cycle after an access ends so a still-held request is not re-granted
    // before the requester has seen its completion pulse.
    logic          cool, cool_nxt;
    logic          mem_en_nxt, mem_we_nxt, mem_err_nxt;
    logic          complete_instr_nxt, complete_data_nxt;
    logic [AW-1:0] mem_addr_nxt, data_sel_addr;
    logic [DW-1:0] mem_wdata_nxt, instr_dout_nxt, data_dout_nxt;
    logic          data_pend, grant_instr, grant_data;

    assign op_in         = mem_state_t'(mem_state);
    assign data_pend     = (op_in != MEM_IDLE) && (op_in != served_op);
    assign grant_instr   = instr_req && (!data_pend || (starve_cnt == STARVE_MAX));
    assign grant_data    = data_pend && !grant_instr;
    // Second half of an indirect chain targets the pointer fetched by the DIND access.
    assign data_sel_addr = ind_valid ? ind_ptr : data_addr;

    // Register all state and outputs; reset overrides anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_IDLE;
            served_op      <= MEM_IDLE;
            ind_valid      <= 1'b0;
            ind_ptr        <= '0;
            wait_cnt       <= '0;
            starve_cnt     <= '0;
            cool           <= 1'b0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            instr_dout     <= '0;
            complete_instr <= 1'b0;
            data_dout      <= '0;
            complete_data  <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            state          <= state_nxt;
            served_op      <= served_op_nxt;
            ind_valid      <= ind_valid_nxt;
            ind_ptr        <= ind_ptr_nxt;
            wait_cnt       <= wait_cnt_nxt;
            starve_cnt     <= starve_cnt_nxt;
            cool           <= cool_nxt;
            mem_en         <= mem_en_nxt;
            mem_we         <= mem_we_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_wdata      <= mem_wdata_nxt;
            instr_dout     <= instr_dout_nxt;
            complete_instr <= complete_instr_nxt;
            data_dout      <= data_dout_nxt;
            complete_data  <= complete_data_nxt;
            mem_err        <= mem_err_nxt;
        end
    end

    // Arbitrate in IDLE, sequence the access, and handle completion / watchdog abort.
    always_comb begin
        state_nxt          = state;
        served_op_nxt      = served_op;
        ind_valid_nxt      = ind_valid;
        ind_ptr_nxt        = ind_ptr;
        wait_cnt_nxt       = wait_cnt;
        starve_cnt_nxt     = starve_cnt;
        cool_nxt           = 1'b0;
        mem_en_nxt         = mem_en;
        mem_we_nxt         = mem_we;
        mem_addr_nxt       = mem_addr;
        mem_wdata_nxt      = mem_wdata;
        instr_dout_nxt     = instr_dout;
        complete_instr_nxt = 1'b0;
        data_dout_nxt      = data_dout;
        complete_data_nxt  = 1'b0;
        mem_err_nxt        = mem_err;

        case (state)
            ARB_IDLE: begin
                if (!cool && grant_instr) begin
                    state_nxt      = ARB_INSTR;
                    mem_en_nxt     = 1'b1;
                    mem_we_nxt     = 1'b0;
                    mem_addr_nxt   = instr_addr;
                    wait_cnt_nxt   = '0;
                    starve_cnt_nxt = '0;
                end else if (!cool && grant_data) begin
                    mem_en_nxt   = 1'b1;
                    mem_we_nxt   = 1'b0;
                    wait_cnt_nxt = '0;
                    if (instr_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt_nxt = starve_cnt + 1'b1;
                    end
                    case (op_in)
                        MEM_IND: begin
                            state_nxt    = ARB_DIND;
                            mem_addr_nxt = data_addr;
                        end
                        MEM_WR: begin
                            state_nxt     = ARB_DWR;
                            mem_we_nxt    = 1'b1;
                            mem_addr_nxt  = data_sel_addr;
                            mem_wdata_nxt = data_din;
                        end
                        default: begin
                            state_nxt    = ARB_DRD;
                            mem_addr_nxt = data_sel_addr;
                        end
                    endcase
                end
            end
            default: begin
                if (mem_ready) begin
                    state_nxt  = ARB_IDLE;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    cool_nxt   = 1'b1;
                    case (state)
                        ARB_INSTR: begin
                            complete_instr_nxt = 1'b1;
                            instr_dout_nxt     = mem_rdata;
                        end
                        ARB_DIND: begin
                            complete_data_nxt = 1'b1;
                            data_dout_nxt     = mem_rdata;
                            ind_ptr_nxt       = AW'(mem_rdata);
                            ind_valid_nxt     = 1'b1;
                            served_op_nxt     = MEM_IND;
                        end
                        ARB_DWR: begin
                            complete_data_nxt = 1'b1;
                            ind_valid_nxt     = 1'b0;
                            served_op_nxt     = MEM_WR;
                        end
                        default: begin
                            complete_data_nxt = 1'b1;
                            data_dout_nxt     = mem_rdata;
                            ind_valid_nxt     = 1'b0;
                            served_op_nxt     = MEM_RD;
                        end
                    endcase
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abort leaves served_op alone so the same op is retried.
                    state_nxt   = ARB_IDLE;
                    mem_en_nxt  = 1'b0;
                    mem_we_nxt  = 1'b0;
                    mem_err_nxt = 1'b1;
                    cool_nxt    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
        endcase

        if (!instr_req) begin
            starve_cnt_nxt = '0;
        end
        if (op_in == MEM_IDLE) begin
            served_op_nxt = MEM_IDLE;
            ind_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Purpose: self-checking bench for lc3_mem_arbiter with a behavioural memory and event scoreboard.
// Latency: memory answers in the lat-th cycle of mem_en; controller reacts to completion pulses.
// Backpressure: no_ready holds mem_ready low to exercise the watchdog.
module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic [1:0]  mem_state;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] instr_dout;
    logic        complete_instr;
    logic [15:0] data_dout;
    logic        complete_data;
    logic        mem_err;

    lc3_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req      (instr_req),
        .instr_addr     (instr_addr),
        .mem_state      (mem_state),
        .data_addr      (data_addr),
        .data_din       (data_din),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .instr_dout     (instr_dout),
        .complete_instr (complete_instr),
        .data_dout      (data_dout),
        .complete_data  (complete_data),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic        we;
        logic [15:0] val;
    } ev_t;

    localparam logic [1:0] K_ACC = 2'd0;
    localparam logic [1:0] K_CI  = 2'd1;
    localparam logic [1:0] K_CD  = 2'd2;

    ev_t         exp_q[$];
    logic [1:0]  op_q[$];
    logic [15:0] mem [0:65535];
    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;
    bit          no_ready = 1'b0;
    int          acc_cnt  = 0;

    function automatic void push_ev(input logic [1:0] k, input logic [15:0] a,
                                    input logic w, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.we   = w;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic score(input ev_t act);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d addr=%h we=%b val=%h required=none",
                     act.kind, act.addr, act.we, act.val);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL event got kind=%0d addr=%h we=%b val=%h required kind=%0d addr=%h we=%b val=%h",
                         act.kind, act.addr, act.we, act.val, e.kind, e.addr, e.we, e.val);
            end
        end
    endtask

    // Monitor: every memory handshake and completion pulse is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_en && mem_ready)
                    score(ev_t'({K_ACC, mem_addr, mem_we, (mem_we ? mem_wdata : 16'h0000)}));
                if (complete_instr)
                    score(ev_t'({K_CI, 16'h0000, 1'b0, instr_dout}));
                if (complete_data)
                    score(ev_t'({K_CD, 16'h0000, 1'b0, data_dout}));
            end
        end
    end

    // Behavioural memory: answers in the lat-th cycle of mem_en unless no_ready is set.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                acc_cnt++;
                if (!no_ready && acc_cnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                acc_cnt   = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Controller model: steps through op_q on complete_data, drops instr_req on complete_instr.
    task automatic run(input bit fetch, input int budget, input string name);
        int idx = 0;
        bit done = 1'b0;
        instr_req = fetch;
        mem_state = (op_q.size() > 0) ? op_q[0] : 2'd3;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (complete_data) begin
                idx++;
                mem_state = (idx < op_q.size()) ? op_q[idx] : 2'd3;
            end
            if (complete_instr) instr_req = 1'b0;
            done = (idx >= op_q.size()) && !instr_req;
        end
        check(name, {31'd0, done}, 32'd1);
        instr_req = 1'b0;
        mem_state = 2'd3;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit got;
        rst        = 1'b1;
        instr_req  = 1'b0;
        instr_addr = 16'h0000;
        mem_state  = 2'd3;
        data_addr  = 16'h0000;
        data_din   = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'h1234;
        mem[16'h3002] = 16'h3232;
        mem[16'h3004] = 16'h3434;
        mem[16'h4000] = 16'h4444;
        mem[16'h4100] = 16'h4141;
        mem[16'h4300] = 16'h4343;
        mem[16'h5000] = 16'h6000;
        mem[16'h6000] = 16'h7777;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {27'd0, mem_en, mem_we, complete_instr, complete_data, mem_err}, 32'd0);
        check("rst_addr", {mem_addr, mem_wdata}, 32'd0);
        check("rst_dout", {instr_dout, data_dout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch only, memory answers in the second mem_en cycle.
        lat = 2;
        instr_addr = 16'h3000;
        op_q = {};
        push_ev(K_ACC, 16'h3000, 1'b0, 16'h0000);
        push_ev(K_CI,  16'h0000, 1'b0, 16'h1234);
        run(1'b1, 30, "fetch_done");

        // Contention: data wins first, then fetch.
        lat = 1;
        instr_addr = 16'h3002;
        data_addr  = 16'h4000;
        op_q = {2'd0};
        push_ev(K_ACC, 16'h4000, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h4444);
        push_ev(K_ACC, 16'h3002, 1'b0, 16'h0000);
        push_ev(K_CI,  16'h0000, 1'b0, 16'h3232);
        run(1'b1, 30, "contention_done");

        // LDI: pointer read then read through the pointer.
        data_addr = 16'h5000;
        op_q = {2'd1, 2'd0};
        push_ev(K_ACC, 16'h5000, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h6000);
        push_ev(K_ACC, 16'h6000, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h7777);
        run(1'b0, 30, "ldi_done");

        // STI: pointer read then write through the pointer; data_dout keeps the pointer.
        data_din = 16'hBEEF;
        op_q = {2'd1, 2'd2};
        push_ev(K_ACC, 16'h5000, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h6000);
        push_ev(K_ACC, 16'h6000, 1'b1, 16'hBEEF);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h6000);
        run(1'b0, 30, "sti_done");

        // Held op code gives one write; a pass through idle allows the next.
        data_addr = 16'h4200;
        data_din  = 16'h1111;
        push_ev(K_ACC, 16'h4200, 1'b1, 16'h1111);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h6000);
        mem_state = 2'd2;
        repeat (10) @(negedge clk);
        mem_state = 2'd3;
        @(negedge clk);
        data_din = 16'h2222;
        push_ev(K_ACC, 16'h4200, 1'b1, 16'h2222);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h6000);
        mem_state = 2'd2;
        repeat (10) @(negedge clk);
        mem_state = 2'd3;
        repeat (3) @(negedge clk);

        // Starvation: fetch forced after the fourth consecutive data grant.
        instr_addr = 16'h3004;
        data_addr  = 16'h4100;
        data_din   = 16'hA5A5;
        op_q = {2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        push_ev(K_ACC, 16'h4100, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h4141);
        push_ev(K_ACC, 16'h4100, 1'b1, 16'hA5A5);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h4141);
        push_ev(K_ACC, 16'h4100, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'hA5A5);
        push_ev(K_ACC, 16'h4100, 1'b1, 16'hA5A5);
        push_ev(K_CD,  16'h0000, 1'b0, 16'hA5A5);
        push_ev(K_ACC, 16'h3004, 1'b0, 16'h0000);
        push_ev(K_CI,  16'h0000, 1'b0, 16'h3434);
        push_ev(K_ACC, 16'h4100, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'hA5A5);
        push_ev(K_ACC, 16'h4100, 1'b1, 16'hA5A5);
        push_ev(K_CD,  16'h0000, 1'b0, 16'hA5A5);
        run(1'b1, 80, "starve_done");

        // Watchdog: no mem_ready, abort after 15 cycles, then the same read is retried.
        no_ready  = 1'b1;
        data_addr = 16'h4300;
        mem_state = 2'd0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = mem_en;
        end
        check("timeout_start", {31'd0, got}, 32'd1);
        cnt = 0;
        while (mem_en && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_len", cnt, 32'd15);
        check("mem_err_set", {31'd0, mem_err}, 32'd1);
        no_ready = 1'b0;
        op_q = {2'd0};
        push_ev(K_ACC, 16'h4300, 1'b0, 16'h0000);
        push_ev(K_CD,  16'h0000, 1'b0, 16'h4343);
        run(1'b0, 40, "retry_done");
        check("mem_err_sticky", {31'd0, mem_err}, 32'd1);

        // Reset in the middle of an access drops it with no completion.
        lat = 5;
        data_addr = 16'h4400;
        mem_state = 2'd0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = mem_en;
        end
        check("rst_mid_start", {31'd0, got}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        mem_state = 2'd3;
        @(negedge clk);
        check("rst_mid_ctrl", {27'd0, mem_en, mem_we, complete_instr, complete_data, mem_err}, 32'd0);
        check("rst_mid_addr", {mem_addr, mem_wdata}, 32'd0);
        check("rst_mid_dout", {instr_dout, data_dout}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_quiet", {31'd0, mem_en}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
